// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point normalise/round block:
// controller states, FP16 default field widths and field offsets.
package fpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FP16_MANT_W   = 10;
    localparam int FP16_EXP_W    = 5;

    // Bit positions of the packed {sign, exp, frac} result.
    localparam int FRAC_LSB      = 0;
    localparam int FP16_EXP_LSB  = FRAC_LSB + FP16_MANT_W;
    localparam int FP16_SIGN_BIT = FP16_EXP_LSB + FP16_EXP_W;

endpackage

// File: rtl/fp_rne_round.sv
// Combinational round-to-nearest-even of a normalised (or subnormal)
// mantissa with guard/round/sticky bits, including exponent encoding
// and saturation to infinity.
module fp_rne_round
    import fpu_pkg::*;
#(
    parameter int MANT_W = FP16_MANT_W,
    parameter int EXP_W  = FP16_EXP_W
) (
    input  logic [MANT_W:0]   i_m,
    input  logic              i_g,
    input  logic              i_r,
    input  logic              i_s,
    input  logic [EXP_W:0]    i_exp,
    output logic [MANT_W-1:0] o_frac,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_inexact,
    output logic              o_overflow
);

    // Nearest-even: round up above half, or at exactly half when the lsb is odd.
    function automatic logic rne_up(input logic g, input logic r, input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

    // Any encoded exponent at or above all-ones cannot be represented.
    function automatic logic exp_saturates(input logic [EXP_W:0] e);
        return e >= {1'b0, {EXP_W{1'b1}}};
    endfunction

    logic [MANT_W+1:0] w_sum;
    logic [MANT_W:0]   w_m;
    logic [EXP_W:0]    w_exp_post;
    logic [EXP_W:0]    w_exp_enc;
    logic              w_ovf;

    // Increment, renormalise on carry-out, encode the exponent field and saturate.
    always_comb begin
        w_sum      = {1'b0, i_m} + {{(MANT_W+1){1'b0}}, rne_up(i_g, i_r, i_s, i_m[0])};
        w_m        = w_sum[MANT_W+1] ? w_sum[MANT_W+1:1] : w_sum[MANT_W:0];
        w_exp_post = i_exp + {{EXP_W{1'b0}}, w_sum[MANT_W+1]};
        // No hidden bit means subnormal (exp field 0); a subnormal that rounds
        // up into the hidden bit becomes the smallest normal, exponent 1.
        if (!w_m[MANT_W]) begin
            w_exp_enc = '0;
        end else if (w_exp_post == '0) begin
            w_exp_enc = {{EXP_W{1'b0}}, 1'b1};
        end else begin
            w_exp_enc = w_exp_post;
        end
        w_ovf      = exp_saturates(w_exp_enc);
        o_frac     = w_ovf ? '0 : w_m[MANT_W-1:0];
        o_exp      = w_ovf ? '1 : w_exp_enc[EXP_W-1:0];
        o_inexact  = w_ovf | i_g | i_r | i_s;
        o_overflow = w_ovf;
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normaliser and rounder: accepts an adder sum with G/R/S bits,
// normalises (right by one on carry, left one bit per cycle otherwise),
// rounds to nearest-even and presents a held {sign, exp, frac} result.
module fp_norm_round
    import fpu_pkg::*;
#(
    parameter int MANT_W = FP16_MANT_W,
    parameter int EXP_W  = FP16_EXP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sign,
    input  logic [EXP_W-1:0]      in_exp,
    input  logic [MANT_W+1:0]     in_sum,
    input  logic [2:0]            in_grs,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_W+MANT_W:0] out_result,
    output logic                  out_inexact,
    output logic                  out_overflow
);

    localparam int EXP_LSB  = FRAC_LSB + MANT_W;
    localparam int SIGN_POS = EXP_LSB + EXP_W;

    state_t r_state;
    state_t w_next;

    // Working operand; the exponent carries one spare bit so a carry
    // increment of an all-ones exponent cannot wrap.
    logic              r_sign;
    logic [MANT_W:0]   r_m;
    logic              r_g;
    logic              r_r;
    logic              r_s;
    logic [EXP_W:0]    r_exp;

    logic [EXP_W+MANT_W:0] r_result;
    logic                  r_inexact;
    logic                  r_overflow;

    logic              w_accept;
    logic              w_zero;
    logic              w_norm_done;
    logic [MANT_W-1:0] w_rnd_frac;
    logic [EXP_W-1:0]  w_rnd_exp;
    logic              w_rnd_inexact;
    logic              w_rnd_overflow;

    assign in_ready     = (r_state == ST_IDLE);
    assign out_valid    = (r_state == ST_DONE);
    assign out_result   = r_result;
    assign out_inexact  = r_inexact;
    assign out_overflow = r_overflow;

    assign w_accept    = in_valid && in_ready;
    assign w_zero      = (in_sum == '0) && (in_grs == 3'b000);
    // Stop shifting once normalised, or at the minimum exponent (subnormal).
    assign w_norm_done = r_m[MANT_W] || (r_exp <= {{EXP_W{1'b0}}, 1'b1});

    fp_rne_round #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_round (
        .i_m        (r_m),
        .i_g        (r_g),
        .i_r        (r_r),
        .i_s        (r_s),
        .i_exp      (r_exp),
        .o_frac     (w_rnd_frac),
        .o_exp      (w_rnd_exp),
        .o_inexact  (w_rnd_inexact),
        .o_overflow (w_rnd_overflow)
    );

    // State register; reset wins over every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = w_zero ? ST_DONE : ST_NORM;
            ST_NORM:  if (w_norm_done) w_next = ST_ROUND;
            ST_ROUND: w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Operand capture on acceptance and one left shift per NORM cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_sign <= in_sign;
            if (in_sum[MANT_W+1]) begin
                r_m   <= in_sum[MANT_W+1:1];
                r_g   <= in_sum[0];
                r_r   <= in_grs[2];
                r_s   <= in_grs[1] | in_grs[0];
                r_exp <= {1'b0, in_exp} + {{EXP_W{1'b0}}, 1'b1};
            end else begin
                r_m   <= in_sum[MANT_W:0];
                r_g   <= in_grs[2];
                r_r   <= in_grs[1];
                r_s   <= in_grs[0];
                r_exp <= {1'b0, in_exp};
            end
        end else if (r_state == ST_NORM && !w_norm_done) begin
            r_m   <= {r_m[MANT_W-1:0], r_g};
            r_g   <= r_r;
            r_r   <= 1'b0;
            r_exp <= r_exp - {{EXP_W{1'b0}}, 1'b1};
        end
    end

    // Result registers: loaded for an exact zero or on leaving ROUND, then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result   <= '0;
            r_inexact  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_accept && w_zero) begin
            r_result           <= '0;
            r_result[SIGN_POS] <= in_sign;
            r_inexact          <= 1'b0;
            r_overflow         <= 1'b0;
        end else if (r_state == ST_ROUND) begin
            r_result[SIGN_POS]          <= r_sign;
            r_result[EXP_LSB +: EXP_W]  <= w_rnd_exp;
            r_result[FRAC_LSB +: MANT_W] <= w_rnd_frac;
            r_inexact                   <= w_rnd_inexact;
            r_overflow                  <= w_rnd_overflow;
        end
    end

endmodule
